// File: rtl/hci_stream_downsizer_pkg.sv
// Shared types for the HCI stream downsizer: streamer FSM states and the
// control/flag structs exchanged with the controller.
package hci_stream_downsizer_pkg;

    localparam int unsigned HCI_DS_TRANS_CNT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DONE    = 2'd2
    } hci_streamer_state_t;

    typedef struct packed {
        logic                        req_start;
        logic [HCI_DS_TRANS_CNT-1:0] tot_len;
    } hci_downsizer_ctrl_t;

    typedef struct packed {
        logic                        ready_start;
        logic                        done;
        logic [HCI_DS_TRANS_CNT-1:0] beat_cnt;
    } hci_downsizer_flags_t;

endpackage

// File: rtl/hci_stream_downsizer_if.sv
// HWPE-Stream handshake bundle: data, byte strobes, valid/ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hci_stream_downsizer.sv
// Splits each wide stream word into R narrow beats, LS slice first, and stops
// after a programmed number of output beats.
module hci_stream_downsizer
    import hci_stream_downsizer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned TRANS_CNT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o,
    input  hci_downsizer_ctrl_t   ctrl_i,
    output hci_downsizer_flags_t  flags_o
);

    localparam int unsigned R       = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W   = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned IN_STRB = IN_WIDTH / 8;
    localparam int unsigned OUT_STRB = OUT_WIDTH / 8;

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || R == 0 || (R & (R - 1)) != 0 ||
            TRANS_CNT != HCI_DS_TRANS_CNT) begin : g_bad_params
            $fatal(1, "hci_stream_downsizer: illegal width/counter parameters");
        end
    endgenerate

    hci_streamer_state_t  state;
    logic [IN_WIDTH-1:0]  buf_data;
    logic [IN_STRB-1:0]   buf_strb;
    logic                 buf_valid;
    logic [IDX_W-1:0]     idx;
    logic [TRANS_CNT-1:0] beat_cnt;
    logic [TRANS_CNT-1:0] tot_len_q;

    logic working, out_valid, out_hs, in_ready, in_hs, last_slice, last_beat;

    assign working    = enable_i & (state == WORKING);
    assign out_valid  = working & buf_valid;
    assign out_hs     = out_valid & stream_o.ready;
    assign last_slice = (idx == IDX_W'(R - 1));
    assign last_beat  = (beat_cnt == tot_len_q - TRANS_CNT'(1));
    // Refill in the same cycle the last slice leaves, unless that beat ends the transfer.
    assign in_ready   = working & (~buf_valid | (out_hs & last_slice & ~last_beat));
    assign in_hs      = in_ready & stream_i.valid;

    assign stream_i.ready = in_ready;
    assign stream_o.valid = out_valid;
    assign stream_o.data  = buf_data[idx*OUT_WIDTH +: OUT_WIDTH];
    assign stream_o.strb  = buf_strb[idx*OUT_STRB +: OUT_STRB];

    assign flags_o.ready_start = (state == IDLE);
    assign flags_o.done        = (state == DONE);
    assign flags_o.beat_cnt    = beat_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            buf_data  <= '0;
            buf_strb  <= '0;
            buf_valid <= 1'b0;
            idx       <= '0;
            beat_cnt  <= '0;
            tot_len_q <= '0;
        end else if (clear_i) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            idx       <= '0;
            beat_cnt  <= '0;
        end else if (enable_i) begin
            case (state)
                IDLE: begin
                    if (ctrl_i.req_start) begin
                        tot_len_q <= ctrl_i.tot_len;
                        state     <= (ctrl_i.tot_len != '0) ? WORKING : DONE;
                    end
                end
                WORKING: begin
                    if (out_hs) begin
                        beat_cnt <= beat_cnt + TRANS_CNT'(1);
                        idx      <= last_slice ? '0 : idx + IDX_W'(1);
                        if (last_slice) buf_valid <= 1'b0;
                        if (last_beat) state <= DONE;
                    end
                    if (in_hs) begin
                        buf_data  <= stream_i.data;
                        buf_strb  <= stream_i.strb;
                        buf_valid <= 1'b1;
                    end
                end
                DONE: begin
                    buf_valid <= 1'b0;
                    idx       <= '0;
                    beat_cnt  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hci_stream_downsizer.sv
// Directed bench for hci_stream_downsizer (128 -> 32, four slices per word).
module tb_hci_stream_downsizer;
    import hci_stream_downsizer_pkg::*;

    logic clk = 1'b0;
    logic rst_n, clear, enable;
    hci_downsizer_ctrl_t  ctrl;
    hci_downsizer_flags_t flags;
    int tests = 0;
    int fails = 0;

    logic [127:0] words [3];
    logic [15:0]  strbs [3];
    logic [31:0]  exp_d [8];
    logic [3:0]   exp_s [8];

    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) s_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  s_out ();

    always #5 clk = ~clk;

    hci_stream_downsizer dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .enable_i (enable),
        .stream_i (s_in),
        .stream_o (s_out),
        .ctrl_i   (ctrl),
        .flags_o  (flags)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full transfer; bp selects the 1,0,0,1 output-ready pattern.
    task automatic run_xfer(input int tot, input int nw, input bit bp, input int exp_acc);
        int k = 0, wi = 0, cyc = 0, acc_cyc1 = -1, out_cyc3 = -1;
        bit held = 0, seen_done = 0;
        logic [31:0] held_d = '0;
        @(negedge clk);
        ctrl.req_start = 1'b1;
        ctrl.tot_len   = tot[15:0];
        s_in.valid = (nw > 0);
        s_in.data  = words[0];
        s_in.strb  = strbs[0];
        s_out.ready = 1'b1;
        #1 chk("ready_start_idle", flags.ready_start, 1);
        chk("in_ready_idle", s_in.ready, 0);
        @(negedge clk);
        ctrl.req_start = 1'b0;
        while (cyc < 200 && !seen_done) begin
            s_out.ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            s_in.valid = (wi < nw);
            if (wi < nw) begin
                s_in.data = words[wi];
                s_in.strb = strbs[wi];
            end
            #1;
            if (flags.done) begin
                seen_done = 1;
            end else begin
                if (s_in.valid && s_in.ready) begin
                    if (wi == 1) acc_cyc1 = cyc;
                    wi++;
                end
                if (held) begin
                    chk("hold_valid", s_out.valid, 1);
                    chk("hold_data", s_out.data, held_d);
                end
                held   = s_out.valid && !s_out.ready;
                held_d = s_out.data;
                if (s_out.valid && s_out.ready) begin
                    if (k < 8) begin
                        chk($sformatf("beat%0d_data", k), s_out.data, exp_d[k]);
                        chk($sformatf("beat%0d_strb", k), s_out.strb, exp_s[k]);
                    end
                    if (k == 3) out_cyc3 = cyc;
                    k++;
                end
                cyc++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen_done, 1);
        chk("beats_out", k, tot);
        chk("beat_cnt_done", flags.beat_cnt, tot);
        chk("words_accepted", wi, exp_acc);
        chk("valid_in_done", s_out.valid, 0);
        if (!bp && tot == 8) chk("refill_same_cycle", acc_cyc1, out_cyc3);
        @(negedge clk);
        s_in.valid = 1'b0;
        #1 chk("done_one_cycle", flags.done, 0);
        chk("ready_start_after", flags.ready_start, 1);
        chk("beat_cnt_after", flags.beat_cnt, 0);
    endtask

    initial begin
        int hs, wi, cyc;
        words[0] = 128'h44443333_22221111_0000FFFF_EEEEDDDD;
        words[1] = 128'h88887777_66665555_BBBBAAAA_CCCC9999;
        words[2] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        strbs[0] = 16'h8421;
        strbs[1] = 16'hF0C3;
        strbs[2] = 16'hFFFF;
        exp_d = '{32'hEEEEDDDD, 32'h0000FFFF, 32'h22221111, 32'h44443333,
                  32'hCCCC9999, 32'hBBBBAAAA, 32'h66665555, 32'h88887777};
        exp_s = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0, 4'hF};

        rst_n = 1'b1; clear = 1'b0; enable = 1'b1;
        ctrl = '0;
        s_in.valid = 1'b0; s_in.data = '0; s_in.strb = '0;
        s_out.ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", s_out.valid, 0);
        chk("rst_in_ready", s_in.ready, 0);
        chk("rst_ready_start", flags.ready_start, 1);
        chk("rst_done", flags.done, 0);
        chk("rst_beat_cnt", flags.beat_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(8, 2, 1'b0, 2);   // basic
        run_xfer(6, 3, 1'b0, 2);   // partial final word, third word left upstream
        run_xfer(8, 2, 1'b1, 2);   // backpressure
        run_xfer(0, 1, 1'b0, 0);   // zero length

        // clear after five output beats
        @(negedge clk);
        ctrl.req_start = 1'b1; ctrl.tot_len = 16'd16;
        s_in.valid = 1'b1; s_in.data = words[0]; s_in.strb = strbs[0];
        s_out.ready = 1'b1;
        hs = 0; wi = 0; cyc = 0;
        while (hs < 5 && cyc < 50) begin
            @(negedge clk);
            ctrl.req_start = 1'b0;
            s_in.data = words[wi % 2];
            s_in.strb = strbs[wi % 2];
            #1;
            if (s_in.valid && s_in.ready) wi++;
            if (s_out.valid && s_out.ready) hs++;
            cyc++;
        end
        chk("clear_pre_beats", hs, 5);
        @(negedge clk);
        enable = 1'b0;
        #1 chk("en_low_valid", s_out.valid, 0);
        chk("en_low_in_ready", s_in.ready, 0);
        chk("en_low_beat_cnt", flags.beat_cnt, 5);
        @(negedge clk);
        enable = 1'b1; clear = 1'b1;
        #1 chk("en_hold_data", s_out.data, 32'hBBBBAAAA);
        @(negedge clk);
        clear = 1'b0; s_in.valid = 1'b0;
        #1 chk("clear_ready_start", flags.ready_start, 1);
        chk("clear_beat_cnt", flags.beat_cnt, 0);
        chk("clear_done", flags.done, 0);
        chk("clear_valid", s_out.valid, 0);
        run_xfer(8, 2, 1'b0, 2);

        // asynchronous reset mid-transfer
        @(negedge clk);
        ctrl.req_start = 1'b1; ctrl.tot_len = 16'd8;
        s_in.valid = 1'b1; s_in.data = words[0]; s_in.strb = strbs[0];
        @(negedge clk);
        ctrl.req_start = 1'b0;
        @(negedge clk);
        #1 chk("pre_reset_valid", s_out.valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", s_out.valid, 0);
        chk("async_rst_ready_start", flags.ready_start, 1);
        chk("async_rst_in_ready", s_in.ready, 0);
        chk("async_rst_beat_cnt", flags.beat_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1; s_in.valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hci_stream_downsizer.md
Name: hci_stream_downsizer

Overview:
- Sits directly downstream of the HCI-Core source streamer.
- Consumes its wide HWPE-Stream (one TCDM word per beat) and re-emits it as a sequence of narrower beats for an engine datapath, least-significant slice first.
- A programmable beat count terminates the transfer. Slices left unused in the final wide word are discarded.
- Exposes a start/done handshake matching the other streamers.

Parameters:
- IN_WIDTH, 128: data width of the input stream.
- OUT_WIDTH, 32: data width of the output stream. IN_WIDTH/OUT_WIDTH = R must be an integer power of two, R >= 1.
- TRANS_CNT, 16: width of the output-beat counter and of tot_len.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous clear, highest priority after reset.
- enable_i  input  1  global enable; when low, all state is frozen and both valid/ready outputs are 0.
- stream_i  hwpe_stream_intf_stream.sink  IN_WIDTH  wide input stream (data, strb, valid, ready).
- stream_o  hwpe_stream_intf_stream.source  OUT_WIDTH  narrow output stream.
- ctrl_i  input  struct  hci_downsizer_ctrl_t {req_start, tot_len[TRANS_CNT-1:0]}.
- flags_o  output  struct  hci_downsizer_flags_t {ready_start, done, beat_cnt[TRANS_CNT-1:0]}.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values:
  - state IDLE, buffer empty, index 0, beat_cnt 0, tot_len_q 0.
  - stream_o.valid=0, stream_i.ready=0, flags_o.ready_start=1, flags_o.done=0.
- FSM (hci_streamer_state_t):
  - IDLE: ready_start=1. On req_start: sample tot_len into tot_len_q. Go to WORKING if tot_len!=0, else go to DONE.
  - WORKING: transfer beats. When an output handshake occurs with beat_cnt == tot_len_q-1, go to DONE.
  - DONE: done=1 for exactly this one cycle (Moore). Clear buffer valid, index and beat_cnt. Go to IDLE.
- Buffer: one wide data register plus strb register, buf_valid, and a log2(R)-bit index.
- Input ready: stream_i.ready = enable_i & WORKING & (~buf_valid | last_slice_accept).
  - last_slice_accept = stream_o handshake & index==R-1 & transfer not ending this cycle.
  - This gives full throughput: a new wide word loads in the same cycle the last slice leaves.
- Output:
  - stream_o.valid = enable_i & WORKING & buf_valid.
  - stream_o.data = buf_data[index*OUT_WIDTH +: OUT_WIDTH].
  - stream_o.strb = matching strb slice.
- Output handshake: index increments, wrapping R-1 -> 0. When index wraps and no new word loads, buf_valid clears. beat_cnt increments.
- Latency: first output beat valid one cycle after the input handshake (registered). No combinational path from stream_i.valid to stream_o.valid.
- Final beat: on the output handshake with beat_cnt == tot_len_q-1, any remaining slices are dropped and stream_i.ready stays 0 that cycle.
- Extra input: input words beyond those needed are not accepted; they remain pending upstream.
- R == 1: the block behaves as a one-entry pipeline register with a beat counter.
- clear_i: returns to IDLE and clears the buffer and counters in the next cycle. It overrides an in-flight handshake, which is lost. done is not asserted.
- req_start: ignored outside IDLE.
- Counter: beat_cnt is TRANS_CNT bits. tot_len = 2^TRANS_CNT-1 is the maximum legal value. No wrap occurs before termination.
- enable_i low mid-transfer: no handshakes occur. State, index and buffer are held; the output slice and beat_cnt are unchanged.

Decomposition:
- hci_package additions:
  - hci_downsizer_ctrl_t and hci_downsizer_flags_t.
  - Reuse hci_streamer_state_t (IDLE/WORKING/DONE).
- No sub-module required. The slice register and index are implemented inline. An elaboration-time assertion checks that IN_WIDTH % OUT_WIDTH == 0 and that R is a power of two.

Test Plan:
- Basic: IN=128, OUT=32, tot_len=8, input words 0x44443333_22221111_0000FFFF_EEEEDDDD then 0x88887777_66665555_BBBBAAAA_CCCC9999, stream_o.ready=1 → outputs in order 0xEEEEDDDD, 0x0000FFFF, 0x22221111, 0x44443333, 0xCCCC9999, 0xBBBBAAAA, 0x66665555, 0x88887777. The second word is accepted in the same cycle as the 4th output. done pulses one cycle after the 8th handshake.
- Partial final word: tot_len=6 with 2 input words → 6 beats out, the last 2 slices of word 2 are dropped. A third word offered upstream is never accepted (stream_i.ready=0). done=1 once.
- Backpressure: stream_o.ready toggled 1,0,0,1 repeatedly → stream_o.data held stable while valid & ~ready. No beats lost or duplicated; final beat_cnt=tot_len.
- Zero length: req_start with tot_len=0 → IDLE→DONE→IDLE. done=1 on cycle 2. stream_i.ready never 1.
- Clear mid-transfer: tot_len=16, assert clear_i after 5 output beats → next cycle IDLE, ready_start=1, beat_cnt=0, done never asserted. A new req_start then completes normally.
- Reset mid-transfer: drop rst_ni asynchronously during WORKING → outputs return immediately to reset values (valid=0, ready_start=1).
